lua_inst_encode: RTL and testbench
==================================

# lua_inst_encode

Packs the field-level form of a Lua 5.1 VM instruction (opecode plus operands A/B/C, the same fields the decode stage produces) into a 32-bit instruction word and assigns it a word address for loading into instruction memory. It sits between the program loader/test driver and instruction memory, with valid/ready handshakes on both sides. It checks opcode legality and operand ranges, and reports rejects on a separate error strobe.

## Interface
- ADDR_W, 10: width of the instruction-memory word address counter.

- clk_enc  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field set on opecode/operandA/B/C is valid.
- in_ready  out  1  encoder accepts the field set this cycle.
- opecode  in  8  Lua opcode, legal 0..37.
- operandA  in  8  A field.
- operandB  in  24  B (iABC), Bx (iABx) or signed two's-complement sBx (iAsBx).
- operandC  in  16  C field (iABC only; ignored otherwise).
- addr_clear  in  1  restart address counter at 0.
- out_valid  out  1  out_inst/out_addr hold an encoded word.
- out_ready  in  1  consumer takes the word this cycle.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address for out_inst.
- err_valid  out  1  one-cycle pulse: last accepted field set was rejected.
- err_code  out  2  1 illegal opcode, 2 B/Bx/sBx out of range, 3 C out of range.

## Operation
- Word layout: op[5:0], A[13:6], C[22:14], B[31:23]; Bx = [31:14]; sBx encoded as Bx = sBx + 131071.
- Format by opcode: iABx for LOADK(1), GETGLOBAL(5), SETGLOBAL(7), CLOSURE(36). iAsBx for JMP(22), FORLOOP(31), FORPREP(32). iABC for all other opcodes 0..37.
- Range checks:
  - iABC: operandB <= 511 and operandC <= 511.
  - iABx: operandB <= 262143.
  - iAsBx: -131071 <= operandB <= 131072, signed.
  - operandC is not checked for iABx/iAsBx.
- Error priority: 1 > 2 > 3. A rejected field set is consumed and produces no word. The address counter does not change. err_valid=1 with err_code is set the cycle after acceptance.
- States:
  - EMPTY (out_valid=0) -> FULL on an accepted legal field set.
  - FULL -> EMPTY on out_ready with no new legal acceptance.
  - FULL -> FULL when out_ready and a legal field set are accepted in the same cycle, replacing the word.
- in_ready = !reset && (!out_valid || out_ready), combinational.
- Address counter: a legal word loaded into the output register takes the current counter value as out_addr, and the counter increments. It wraps from 2^ADDR_W-1 to 0 silently.
- addr_clear: the counter becomes 0 next cycle. If a load happens in the same cycle, that word takes the pre-clear value and clear wins over the increment. The word already in the output register is unaffected.

## Timing
- Latency 1: acceptance at edge N gives out_valid/out_inst/out_addr (or err_valid) valid after edge N.
- out_inst and out_addr stay stable while out_valid && !out_ready.
- err_valid lasts exactly one cycle; err_code holds its last value until the next error.
- Reset values: out_valid 0, out_inst 0, out_addr 0, err_valid 0, err_code 0, counter 0; in_ready 0 while reset is high.
- Reset mid-operation drops any held word without handshake.

## Structure
- Package lua_isa_pkg holds:
  - opcode localparams (OP_MOVE..OP_VARARG) and format enum {FMT_ABC, FMT_ABX, FMT_ASBX};
  - field LSB/width constants and SBX_BIAS=131071;
  - MAXARG_BC=511 and MAXARG_BX=262143;
  - ERR_* codes.
- Sub-module lua_op_format: combinational opcode -> {legal, format} lookup, reusable by the decode stage.

## Test plan
- LOADK op=1, A=3, B=5, out_ready=1 -> out_inst 0x000140C1, out_addr 0, next cycle.
- MOVE op=0, A=1, B=2, C=0 then ADD op=12, A=0, B=256, C=257 back-to-back -> 0x01000040 at addr 0, 0x8040400C at addr 1, no bubble.
- JMP op=22, sBx=-1 -> 0x7FFF8016; JMP sBx=131073 -> err_valid, err_code 2, no word, counter unchanged.
- op=40 -> err_code 1. ADD with C=512 -> err_code 3. op=40 with B=600 -> err_code 1 (priority).
- out_ready low 3 cycles with two legal inputs pending -> first word held stable, in_ready=0, second accepted on the release cycle; addresses 0,1.
- ADDR_W=2: five legal words -> addresses 0,1,2,3,0. addr_clear coincident with a load -> that word keeps the old address and the following word gets 0. Reset while FULL -> out_valid 0 next cycle.

Source files
------------

// File: rtl/lua_isa_pkg.sv
// rtl/lua_isa_pkg.sv - Lua 5.1 instruction set constants shared by encode and decode
//
// Purpose: opcode numbers, operand formats, field positions, operand limits
// and encoder reject codes.
package lua_isa_pkg;

  // Opcode numbers
  localparam logic [7:0] OP_MOVE      = 8'd0;
  localparam logic [7:0] OP_LOADK     = 8'd1;
  localparam logic [7:0] OP_LOADBOOL  = 8'd2;
  localparam logic [7:0] OP_LOADNIL   = 8'd3;
  localparam logic [7:0] OP_GETUPVAL  = 8'd4;
  localparam logic [7:0] OP_GETGLOBAL = 8'd5;
  localparam logic [7:0] OP_GETTABLE  = 8'd6;
  localparam logic [7:0] OP_SETGLOBAL = 8'd7;
  localparam logic [7:0] OP_SETUPVAL  = 8'd8;
  localparam logic [7:0] OP_SETTABLE  = 8'd9;
  localparam logic [7:0] OP_NEWTABLE  = 8'd10;
  localparam logic [7:0] OP_SELF      = 8'd11;
  localparam logic [7:0] OP_ADD       = 8'd12;
  localparam logic [7:0] OP_SUB       = 8'd13;
  localparam logic [7:0] OP_MUL       = 8'd14;
  localparam logic [7:0] OP_DIV       = 8'd15;
  localparam logic [7:0] OP_MOD       = 8'd16;
  localparam logic [7:0] OP_POW       = 8'd17;
  localparam logic [7:0] OP_UNM       = 8'd18;
  localparam logic [7:0] OP_NOT       = 8'd19;
  localparam logic [7:0] OP_LEN       = 8'd20;
  localparam logic [7:0] OP_CONCAT    = 8'd21;
  localparam logic [7:0] OP_JMP       = 8'd22;
  localparam logic [7:0] OP_EQ        = 8'd23;
  localparam logic [7:0] OP_LT        = 8'd24;
  localparam logic [7:0] OP_LE        = 8'd25;
  localparam logic [7:0] OP_TEST      = 8'd26;
  localparam logic [7:0] OP_TESTSET   = 8'd27;
  localparam logic [7:0] OP_CALL      = 8'd28;
  localparam logic [7:0] OP_TAILCALL  = 8'd29;
  localparam logic [7:0] OP_RETURN    = 8'd30;
  localparam logic [7:0] OP_FORLOOP   = 8'd31;
  localparam logic [7:0] OP_FORPREP   = 8'd32;
  localparam logic [7:0] OP_TFORLOOP  = 8'd33;
  localparam logic [7:0] OP_SETLIST   = 8'd34;
  localparam logic [7:0] OP_CLOSE     = 8'd35;
  localparam logic [7:0] OP_CLOSURE   = 8'd36;
  localparam logic [7:0] OP_VARARG    = 8'd37;

  typedef enum logic [1:0] {
    FMT_ABC  = 2'd0,
    FMT_ABX  = 2'd1,
    FMT_ASBX = 2'd2
  } fmt_e;

  // Field placement inside the 32-bit word
  localparam int OP_LSB = 0;
  localparam int OP_W   = 6;
  localparam int A_LSB  = 6;
  localparam int A_W    = 8;
  localparam int C_LSB  = 14;
  localparam int C_W    = 9;
  localparam int B_LSB  = 23;
  localparam int B_W    = 9;
  localparam int BX_LSB = 14;
  localparam int BX_W   = 18;

  localparam int SBX_BIAS  = 131071;
  localparam int MAXARG_BC = 511;
  localparam int MAXARG_BX = 262143;

  // Signed window for sBx as seen on the 24-bit operandB port
  localparam logic signed [23:0] SBX_MIN = -24'sd131071;
  localparam logic signed [23:0] SBX_MAX = 24'sd131072;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_RANGE_B = 2'd2;
  localparam logic [1:0] ERR_RANGE_C = 2'd3;

endpackage

// File: rtl/lua_op_format.sv
// rtl/lua_op_format.sv - opcode legality and operand format lookup
//
// Ports:
//   opecode  in  8  Lua opcode
//   legal    out 1  opcode is within 0..37
//   fmt      out    operand format (meaningful only when legal)
module lua_op_format
  import lua_isa_pkg::*;
(
  input  logic [7:0] opecode,
  output logic       legal,
  output fmt_e       fmt
);

  always_comb begin
    legal = (opecode <= OP_VARARG);
    fmt   = FMT_ABC;
    case (opecode)
      OP_LOADK, OP_GETGLOBAL, OP_SETGLOBAL, OP_CLOSURE: fmt = FMT_ABX;
      OP_JMP, OP_FORLOOP, OP_FORPREP:                   fmt = FMT_ASBX;
      default:                                          fmt = FMT_ABC;
    endcase
  end

endmodule

// File: rtl/lua_inst_encode.sv
// rtl/lua_inst_encode.sv - packs Lua 5.1 instruction fields into addressed 32-bit words
//
// Ports:
//   clk_enc, reset            clock, synchronous active-high reset
//   in_valid/in_ready         field-set handshake (opecode, operandA/B/C)
//   addr_clear                restart the word address counter at 0
//   out_valid/out_ready       output word handshake (out_inst, out_addr)
//   err_valid, err_code       one-cycle reject pulse and sticky reject reason
module lua_inst_encode
  import lua_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_enc,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        opecode,
  input  logic [7:0]        operandA,
  input  logic [23:0]       operandB,
  input  logic [15:0]       operandC,
  input  logic              addr_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e state_q, state_d;

  logic              legal;
  fmt_e              fmt;
  logic              b_ok, c_ok;
  logic [1:0]        chk_code;
  logic              accept, load;
  logic [17:0]       bx_field;
  logic [31:0]       word_d;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] addr_q, cnt_q;
  logic              err_valid_q;
  logic [1:0]        err_code_q;

  lua_op_format u_fmt (
    .opecode (opecode),
    .legal   (legal),
    .fmt     (fmt)
  );

  // Operand range checks; C only matters for iABC
  always_comb begin
    b_ok = 1'b1;
    c_ok = 1'b1;
    case (fmt)
      FMT_ABX:  b_ok = (operandB <= 24'(MAXARG_BX));
      FMT_ASBX: b_ok = ($signed(operandB) >= SBX_MIN) && ($signed(operandB) <= SBX_MAX);
      default: begin
        b_ok = (operandB <= 24'(MAXARG_BC));
        c_ok = (operandC <= 16'(MAXARG_BC));
      end
    endcase
  end

  always_comb begin
    chk_code = ERR_NONE;
    if (!legal)      chk_code = ERR_OPCODE;
    else if (!b_ok)  chk_code = ERR_RANGE_B;
    else if (!c_ok)  chk_code = ERR_RANGE_C;
  end

  // Bias addition only needs the low 18 bits: range check guarantees no wrap
  always_comb begin
    bx_field = operandB[17:0];
    if (fmt == FMT_ASBX) bx_field = operandB[17:0] + 18'(SBX_BIAS);
  end

  always_comb begin
    if (fmt == FMT_ABC)
      word_d = {operandB[B_W-1:0], operandC[C_W-1:0], operandA, opecode[OP_W-1:0]};
    else
      word_d = {bx_field, operandA, opecode[OP_W-1:0]};
  end

  assign in_ready = !reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (chk_code == ERR_NONE);

  // FSM: state register
  always_ff @(posedge clk_enc) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (!load && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_q == ST_FULL);
  end

  always_ff @(posedge clk_enc) begin
    if (reset) begin
      inst_q <= '0;
      addr_q <= '0;
    end else if (load) begin
      inst_q <= word_d;
      addr_q <= cnt_q;
    end
  end

  // Clear takes precedence over the post-load increment
  always_ff @(posedge clk_enc) begin
    if (reset || addr_clear) cnt_q <= '0;
    else if (load)           cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk_enc) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      err_valid_q <= accept && (chk_code != ERR_NONE);
      if (accept && (chk_code != ERR_NONE)) err_code_q <= chk_code;
    end
  end

  assign out_inst  = inst_q;
  assign out_addr  = addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_lua_inst_encode.sv
// tb/tb_lua_inst_encode.sv - randomized and directed checks of lua_inst_encode against a reference model
module tb_lua_inst_encode;

  localparam int ADDR_W = 2;
  localparam int NWORDS = 4;

  logic              clk_enc = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        opecode = '0;
  logic [7:0]        operandA = '0;
  logic [23:0]       operandB = '0;
  logic [15:0]       operandC = '0;
  logic              addr_clear = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err_valid;
  logic [1:0]        err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_full;
  logic [31:0] m_inst;
  int          m_addr, m_cnt;
  bit          m_errv;
  int          m_errc;

  always #5 clk_enc = ~clk_enc;

  lua_inst_encode #(.ADDR_W(ADDR_W)) dut (
    .clk_enc    (clk_enc),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opecode    (opecode),
    .operandA   (operandA),
    .operandB   (operandB),
    .operandC   (operandC),
    .addr_clear (addr_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fmt_of(input int op);
    if (op == 1 || op == 5 || op == 7 || op == 36) return 1;
    if (op == 22 || op == 31 || op == 32) return 2;
    return 0;
  endfunction

  function automatic int sbx_of(input logic [23:0] b);
    int v;
    v = int'(b);
    if (v >= 8388608) v = v - 16777216;
    return v;
  endfunction

  function automatic int ref_err(input int op, input logic [23:0] b, input logic [15:0] c);
    int f, s;
    if (op > 37) return 1;
    f = fmt_of(op);
    if (f == 1) return (int'(b) > 262143) ? 2 : 0;
    if (f == 2) begin
      s = sbx_of(b);
      return (s < -131071 || s > 131072) ? 2 : 0;
    end
    if (int'(b) > 511) return 2;
    if (int'(c) > 511) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int a, input logic [23:0] b,
                                           input logic [15:0] c);
    longint w;
    int f;
    f = fmt_of(op);
    if (f == 1)      w = longint'(op) + a * 64 + longint'(b) * 16384;
    else if (f == 2) w = longint'(op) + a * 64 + longint'(sbx_of(b) + 131071) * 16384;
    else             w = longint'(op) + a * 64 + longint'(c) * 16384 + longint'(b) * 8388608;
    return w[31:0];
  endfunction

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs
  task automatic cycle(input bit v, input int op, input int a, input int b, input int c,
                       input bit ordy, input bit clr, input bit rst);
    bit exp_rdy, acc;
    int code;
    in_valid   = v;
    opecode    = op[7:0];
    operandA   = a[7:0];
    operandB   = b[23:0];
    operandC   = c[15:0];
    out_ready  = ordy;
    addr_clear = clr;
    reset      = rst;
    #1;
    exp_rdy = !rst && (!m_full || ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk_enc);
    #1;
    if (rst) begin
      m_full = 0; m_inst = '0; m_addr = 0; m_cnt = 0; m_errv = 0; m_errc = 0;
    end else begin
      acc    = v && exp_rdy;
      code   = ref_err(op & 255, operandB, operandC);
      m_errv = acc && (code != 0);
      if (m_errv) m_errc = code;
      if (acc && code == 0) begin
        m_inst = ref_word(op & 255, a & 255, operandB, operandC);
        m_addr = m_cnt;
        m_full = 1;
        m_cnt  = clr ? 0 : (m_cnt + 1) % NWORDS;
      end else begin
        if (m_full && ordy) m_full = 0;
        if (clr) m_cnt = 0;
      end
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    check("out_inst", out_inst, m_inst);
    check("out_addr", 32'(out_addr), 32'(m_addr));
    check("err_valid", {31'd0, err_valid}, {31'd0, m_errv});
    check("err_code", 32'(err_code), 32'(m_errc));
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int op, a, b, c, sel;
    m_full = 0; m_inst = '0; m_addr = 0; m_cnt = 0; m_errv = 0; m_errc = 0;

    do_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    idle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // LOADK
    cycle(1, 1, 3, 5, 0, 1, 0, 0);
    check("loadk_word", out_inst, 32'h000140C1);
    check("loadk_addr", 32'(out_addr), 32'd0);

    // MOVE then ADD back to back
    do_reset();
    cycle(1, 0, 1, 2, 0, 1, 0, 0);
    check("move_word", out_inst, 32'h01000040);
    check("move_addr", 32'(out_addr), 32'd0);
    cycle(1, 12, 0, 256, 257, 1, 0, 0);
    check("add_word", out_inst, 32'h8040400C);
    check("add_addr", 32'(out_addr), 32'd1);
    idle();

    // JMP sBx=-1, then out-of-range sBx
    do_reset();
    cycle(1, 22, 0, -1, 0, 1, 0, 0);
    check("jmp_word", out_inst, 32'h7FFF8016);
    cycle(1, 22, 0, 131073, 0, 1, 0, 0);
    check("jmp_err_v", {31'd0, err_valid}, 32'd1);
    check("jmp_err_c", 32'(err_code), 32'd2);
    check("jmp_err_noword", {31'd0, out_valid}, 32'd0);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    check("jmp_err_cnt", 32'(out_addr), 32'd1);

    // Error codes and priority
    cycle(1, 40, 0, 0, 0, 1, 0, 0);
    check("err_op", 32'(err_code), 32'd1);
    cycle(1, 12, 0, 0, 512, 1, 0, 0);
    check("err_c", 32'(err_code), 32'd3);
    cycle(1, 40, 0, 600, 0, 1, 0, 0);
    check("err_prio", 32'(err_code), 32'd1);
    idle();
    check("err_pulse", {31'd0, err_valid}, 32'd0);

    // Backpressure: hold first word, second accepted on release
    do_reset();
    cycle(1, 0, 7, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 12, 2, 3, 4, 0, 0, 0);
      check("stall_addr", 32'(out_addr), 32'd0);
    end
    cycle(1, 12, 2, 3, 4, 1, 0, 0);
    check("release_addr", 32'(out_addr), 32'd1);
    idle();

    // Address wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3, i, 0, 0, 1, 0, 0);
      check("wrap_addr", 32'(out_addr), 32'(i % NWORDS));
    end

    // addr_clear coincident with a load
    do_reset();
    cycle(1, 3, 0, 0, 0, 1, 0, 0);
    cycle(1, 3, 0, 0, 0, 1, 0, 0);
    cycle(1, 3, 0, 0, 0, 1, 1, 0);
    check("clr_load_addr", 32'(out_addr), 32'd2);
    cycle(1, 3, 0, 0, 0, 1, 0, 0);
    check("clr_next_addr", 32'(out_addr), 32'd0);

    // Reset while FULL
    cycle(1, 3, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_full", {31'd0, out_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op  = $urandom_range(0, 41);
      a   = $urandom_range(0, 255);
      sel = $urandom_range(0, 4);
      case (sel)
        0: b = $urandom_range(0, 600);
        1: b = 262140 + $urandom_range(0, 6);
        2: b = -131073 + $urandom_range(0, 4);
        3: b = 131069 + $urandom_range(0, 5);
        default: b = $urandom & 24'hFFFFFF;
      endcase
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 520);
      cycle($urandom_range(0, 3) != 0, op, a, b, c, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
